// File: rtl/ram_arbiter.sv
// Arbitrates a single-port data RAM between the CPU memory path and the UART
// bootloader: one transaction at a time, CPU first, loader starvation bounded.
module ram_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_done,
  output logic              cpu_busy,
  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic [DATA_W-1:0] ldr_rdata,
  output logic              ldr_done,
  input  logic              ldr_lock,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [1:0]        owner
);

  typedef enum logic [1:0] {IDLE, WR, RD, RD_WAIT} state_t;

  localparam logic [1:0] OWN_NONE   = 2'b00;
  localparam logic [1:0] OWN_CPU    = 2'b01;
  localparam logic [1:0] OWN_LDR    = 2'b10;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);
  localparam logic [1:0] WAIT_INIT  = 2'(RD_LAT - 2);

  state_t            state, state_next;
  logic [3:0]        starve_cnt, starve_next;
  logic [1:0]        wait_cnt, wait_next;
  logic [1:0]        owner_next;
  logic              ram_en_next, ram_we_next;
  logic [ADDR_W-1:0] ram_addr_next;
  logic [DATA_W-1:0] ram_wdata_next;
  logic [DATA_W-1:0] cpu_rdata_next, ldr_rdata_next;
  logic              cpu_done_next, ldr_done_next;
  logic              cpu_elig, ldr_elig, ldr_win, cpu_win, rd_last;

  // Stall is combinational so the CU freezes in the very cycle a request appears.
  assign cpu_busy = reset & ((cpu_req & ~cpu_done) | ldr_lock);

  // A requester whose done is high this cycle is finishing, not asking again.
  assign cpu_elig = cpu_req & ~cpu_done & ~ldr_lock;
  assign ldr_elig = ldr_req & ~ldr_done;
  assign ldr_win  = ldr_elig & (~cpu_elig | (starve_cnt == STARVE_LIM));
  assign cpu_win  = cpu_elig & ~ldr_win;
  assign rd_last  = ((state == RD) && (RD_LAT == 1)) ||
                    ((state == RD_WAIT) && (wait_cnt == 2'd0));

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_next     = state;
    starve_next    = starve_cnt;
    wait_next      = wait_cnt;
    owner_next     = owner;
    ram_en_next    = 1'b0;
    ram_we_next    = 1'b0;
    ram_addr_next  = ram_addr;
    ram_wdata_next = ram_wdata;
    cpu_rdata_next = cpu_rdata;
    ldr_rdata_next = ldr_rdata;
    cpu_done_next  = 1'b0;
    ldr_done_next  = 1'b0;

    case (state)
      IDLE: begin
        if (ldr_win) begin
          owner_next     = OWN_LDR;
          ram_en_next    = 1'b1;
          ram_we_next    = ldr_we;
          ram_addr_next  = ldr_addr;
          ram_wdata_next = ldr_wdata;
          ldr_done_next  = ldr_we;
          starve_next    = 4'd0;
          state_next     = ldr_we ? WR : RD;
        end else if (cpu_win) begin
          owner_next     = OWN_CPU;
          ram_en_next    = 1'b1;
          ram_we_next    = cpu_we;
          ram_addr_next  = cpu_addr;
          ram_wdata_next = cpu_wdata;
          cpu_done_next  = cpu_we;
          if (ldr_elig && (starve_cnt != STARVE_LIM)) starve_next = starve_cnt + 4'd1;
          state_next     = cpu_we ? WR : RD;
        end
      end
      WR: begin
        owner_next = OWN_NONE;
        state_next = IDLE;
      end
      RD: begin
        wait_next  = WAIT_INIT;
        state_next = RD_WAIT;
      end
      RD_WAIT: wait_next = wait_cnt - 2'd1;
      default: state_next = IDLE;
    endcase

    // Last read cycle: data is valid on ram_rdata now, so hand it to the owner.
    if (rd_last) begin
      owner_next = OWN_NONE;
      state_next = IDLE;
      if (owner == OWN_CPU) begin
        cpu_rdata_next = ram_rdata;
        cpu_done_next  = 1'b1;
      end else begin
        ldr_rdata_next = ram_rdata;
        ldr_done_next  = 1'b1;
      end
    end
  end

  // NOTE: all outputs sit in flops cleared by reset, so an in-flight access is dropped at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      starve_cnt <= 4'd0;
      wait_cnt   <= 2'd0;
      owner      <= OWN_NONE;
      ram_en     <= 1'b0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      cpu_rdata  <= '0;
      ldr_rdata  <= '0;
      cpu_done   <= 1'b0;
      ldr_done   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state      <= state_next;
      starve_cnt <= starve_next;
      wait_cnt   <= wait_next;
      owner      <= owner_next;
      ram_en     <= ram_en_next;
      ram_we     <= ram_we_next;
      ram_addr   <= ram_addr_next;
      ram_wdata  <= ram_wdata_next;
      cpu_rdata  <= cpu_rdata_next;
      ldr_rdata  <= ldr_rdata_next;
      cpu_done   <= cpu_done_next;
      ldr_done   <= ldr_done_next;
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: RAM models, a RAM-access scoreboard fed at stimulus
// time, and directed timing checks for writes, reads, starvation, lock and reset.
module tb_ram_arbiter;

  logic       clk, reset;
  logic       cpu_req, cpu_we, cpu_done, cpu_busy;
  logic [7:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic       ldr_req, ldr_we, ldr_done, ldr_lock;
  logic [7:0] ldr_addr, ldr_wdata, ldr_rdata;
  logic       ram_en, ram_we;
  logic [7:0] ram_addr, ram_wdata, ram_rdata;
  logic [1:0] owner;

  // Second instance with a three-cycle RAM read latency.
  logic       d3_cpu_req, d3_cpu_we, d3_cpu_done, d3_cpu_busy;
  logic [7:0] d3_cpu_addr, d3_cpu_wdata, d3_cpu_rdata;
  logic       d3_ldr_done, d3_ram_en, d3_ram_we;
  logic [7:0] d3_ldr_rdata, d3_ram_addr, d3_ram_wdata, d3_ram_rdata;
  logic [1:0] d3_owner;
  logic       d3_zero_bit;
  logic [7:0] d3_zero_byte;

  logic [7:0]  mem  [256];
  logic [7:0]  mem3 [256];
  logic [7:0]  d3_a1, d3_a2;
  logic        d3_e1, d3_e2;
  logic [18:0] exp_q [$];
  logic [18:0] mon_item;
  logic [7:0]  rd_c, rd_l;
  int          checks = 0;
  int          errors = 0;

  ram_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(1), .STARVE_MAX(4)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_done(cpu_done), .cpu_busy(cpu_busy),
    .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
    .ldr_rdata(ldr_rdata), .ldr_done(ldr_done), .ldr_lock(ldr_lock),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .owner(owner)
  );

  ram_arbiter #(.ADDR_W(8), .DATA_W(8), .RD_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .reset(reset),
    .cpu_req(d3_cpu_req), .cpu_we(d3_cpu_we), .cpu_addr(d3_cpu_addr), .cpu_wdata(d3_cpu_wdata),
    .cpu_rdata(d3_cpu_rdata), .cpu_done(d3_cpu_done), .cpu_busy(d3_cpu_busy),
    .ldr_req(d3_zero_bit), .ldr_we(d3_zero_bit), .ldr_addr(d3_zero_byte), .ldr_wdata(d3_zero_byte),
    .ldr_rdata(d3_ldr_rdata), .ldr_done(d3_ldr_done), .ldr_lock(d3_zero_bit),
    .ram_en(d3_ram_en), .ram_we(d3_ram_we), .ram_addr(d3_ram_addr), .ram_wdata(d3_ram_wdata),
    .ram_rdata(d3_ram_rdata), .owner(d3_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RD_LAT=1 RAM: data valid in the ram_en cycle; 0xEE elsewhere.
  always @(posedge clk) if (ram_en && ram_we) mem[ram_addr] <= ram_wdata;
  assign ram_rdata = ram_en ? mem[ram_addr] : 8'hEE;

  // RD_LAT=3 RAM: data valid two cycles after the ram_en cycle, only for that cycle.
  always @(posedge clk) begin
    d3_a1 <= d3_ram_addr;
    d3_e1 <= d3_ram_en & ~d3_ram_we;
    d3_a2 <= d3_a1;
    d3_e2 <= d3_e1;
  end
  assign d3_ram_rdata = d3_e2 ? mem3[d3_a2] : 8'hEE;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Presents a transaction and returns in the cycle after its done pulse.
  task automatic cpu_txn(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                         output logic [7:0] rdata);
    bit seen = 1'b0;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    rdata = '0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (cpu_done) begin
        seen  = 1'b1;
        rdata = cpu_rdata;
      end
      next_cycle();
    end
    check("cpu_done_seen", 32'(seen), 32'd1);
  endtask

  task automatic ldr_txn(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                         output logic [7:0] rdata);
    bit seen = 1'b0;
    ldr_req = 1'b1; ldr_we = we; ldr_addr = addr; ldr_wdata = wdata;
    rdata = '0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (ldr_done) begin
        seen  = 1'b1;
        rdata = ldr_rdata;
      end
      next_cycle();
    end
    check("ldr_done_seen", 32'(seen), 32'd1);
  endtask

  // Every RAM access must match the next expected {owner, we, addr, wdata}.
  always @(negedge clk) begin
    if (reset && ram_en) begin
      check("sb_avail", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        mon_item = exp_q.pop_front();
        check("sb_access", 32'({owner, ram_we, ram_addr, ram_wdata}), 32'(mon_item));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0; ldr_lock = 0;
    d3_cpu_req = 0; d3_cpu_we = 0; d3_cpu_addr = 0; d3_cpu_wdata = 0;
    d3_zero_bit = 0; d3_zero_byte = 0;
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 8'(i);
      mem3[i] = 8'(i);
    end
    mem[8'h20]  = 8'h3C;
    mem[8'h30]  = 8'h77;
    mem3[8'h20] = 8'h3C;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ram", 32'({ram_en, ram_we, ram_addr, ram_wdata}), 32'd0);
    check("rst_req", 32'({cpu_done, cpu_busy, ldr_done, owner, cpu_rdata, ldr_rdata}), 32'd0);
    next_cycle();
    reset = 1'b1;

    // CPU write: everything visible in cycle 1, busy only in cycle 0.
    next_cycle();
    exp_q.push_back({2'b01, 1'b1, 8'h10, 8'hA5});
    cpu_req = 1; cpu_we = 1; cpu_addr = 8'h10; cpu_wdata = 8'hA5;
    @(negedge clk);
    check("wr_c0_busy", 32'(cpu_busy), 32'd1);
    check("wr_c0_done", 32'(cpu_done), 32'd0);
    next_cycle();
    @(negedge clk);
    check("wr_c1_ram", 32'({ram_en, ram_we, ram_addr, ram_wdata}), 32'({2'b11, 8'h10, 8'hA5}));
    check("wr_c1_done", 32'({cpu_done, owner}), 32'({1'b1, 2'b01}));
    check("wr_c1_busy", 32'(cpu_busy), 32'd0);
    next_cycle();
    cpu_req = 0;
    @(negedge clk);
    check("wr_c2_idle", 32'({ram_en, cpu_done, owner}), 32'd0);

    // CPU read with RD_LAT=1: ram_en in cycle 1, done + data in cycle 2.
    next_cycle();
    exp_q.push_back({2'b01, 1'b0, 8'h20, 8'h00});
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h20; cpu_wdata = 8'h00;
    next_cycle();
    @(negedge clk);
    check("rd1_c1_ram", 32'({ram_en, ram_we, cpu_done}), 32'({3'b100}));
    next_cycle();
    @(negedge clk);
    check("rd1_c2_done", 32'({cpu_done, owner, ram_en}), 32'({1'b1, 2'b00, 1'b0}));
    check("rd1_c2_data", 32'(cpu_rdata), 32'h3C);
    next_cycle();
    cpu_req = 0;

    // CPU read with RD_LAT=3: done only in cycle 4.
    next_cycle();
    d3_cpu_req = 1; d3_cpu_we = 0; d3_cpu_addr = 8'h20;
    @(negedge clk);
    check("rd3_c0_busy", 32'(d3_cpu_busy), 32'd1);
    for (int c = 1; c <= 4; c++) begin
      next_cycle();
      @(negedge clk);
      check("rd3_done", 32'(d3_cpu_done), 32'(c == 4));
      if (c == 1) check("rd3_c1_en", 32'({d3_ram_en, d3_ram_we}), 32'b10);
      if (c == 4) check("rd3_data", 32'(d3_cpu_rdata), 32'h3C);
    end
    next_cycle();
    d3_cpu_req = 0;

    // Both requesters streaming writes: four CPU grants, then one loader grant.
    for (int i = 0; i < 4; i++) exp_q.push_back({2'b01, 1'b1, 8'(8'h40 + i), 8'(8'h60 + i)});
    exp_q.push_back({2'b10, 1'b1, 8'h80, 8'hC0});
    for (int i = 4; i < 8; i++) exp_q.push_back({2'b01, 1'b1, 8'(8'h40 + i), 8'(8'h60 + i)});
    exp_q.push_back({2'b10, 1'b1, 8'h81, 8'hC1});
    next_cycle();
    fork
      begin
        for (int i = 0; i < 8; i++) cpu_txn(1'b1, 8'(8'h40 + i), 8'(8'h60 + i), rd_c);
        cpu_req = 0;
      end
      begin
        for (int j = 0; j < 2; j++) ldr_txn(1'b1, 8'(8'h80 + j), 8'(8'hC0 + j), rd_l);
        ldr_req = 0;
      end
    join
    check("rdata_hold", 32'(cpu_rdata), 32'h3C);

    // Boot lock raised during a CPU read.
    exp_q.push_back({2'b01, 1'b0, 8'h30, 8'h00});
    for (int i = 0; i < 8; i++) exp_q.push_back({2'b10, 1'b1, 8'(i), 8'(8'hB0 + i)});
    exp_q.push_back({2'b01, 1'b1, 8'h50, 8'h99});
    next_cycle();
    fork
      begin
        cpu_txn(1'b0, 8'h30, 8'h00, rd_c);
        check("lock_rd_data", 32'(rd_c), 32'h77);
        cpu_txn(1'b1, 8'h50, 8'h99, rd_c);
        cpu_req = 0;
      end
      begin
        next_cycle();
        ldr_lock = 1;
        next_cycle();
        next_cycle();
        for (int i = 0; i < 8; i++) ldr_txn(1'b1, 8'(i), 8'(8'hB0 + i), rd_l);
        ldr_req  = 0;
        ldr_lock = 0;
      end
      begin
        repeat (3) next_cycle();
        repeat (16) begin
          @(negedge clk);
          check("lock_busy", 32'({cpu_busy, cpu_done}), 32'b10);
        end
      end
    join

    // Reset in cycle 1 of a CPU read, then the held request re-arbitrates.
    exp_q.push_back({2'b01, 1'b0, 8'h03, 8'h00});
    next_cycle();
    cpu_req = 1; cpu_we = 0; cpu_addr = 8'h03; cpu_wdata = 8'h00;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_ram", 32'({ram_en, ram_we, ram_addr, ram_wdata}), 32'd0);
    check("mid_rst_out", 32'({cpu_done, cpu_busy, ldr_done, owner, cpu_rdata, ldr_rdata}), 32'd0);
    next_cycle();
    @(negedge clk);
    check("mid_rst_done", 32'(cpu_done), 32'd0);
    next_cycle();
    reset = 1'b1;
    cpu_txn(1'b0, 8'h03, 8'h00, rd_c);
    cpu_req = 0;
    check("rst_rd_data", 32'(rd_c), 32'hB3);

    // Loader read: its rdata updates, CPU rdata stays put.
    exp_q.push_back({2'b10, 1'b0, 8'h05, 8'h00});
    ldr_txn(1'b0, 8'h05, 8'h00, rd_l);
    ldr_req = 0;
    check("ldr_rd_data", 32'(rd_l), 32'hB5);
    check("ldr_rd_cpu_hold", 32'(cpu_rdata), 32'hB3);

    repeat (3) next_cycle();
    check("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single-port data RAM between two requesters: the CPU memory path (LOAD/STORE RAM accesses driven by the control unit) and the UART bootloader, which writes program/data bytes before and between runs.
- Runs one transaction at a time through a small FSM and gives the CPU priority.
- Bounds loader starvation with a counter.
- Drives a stall flag into the control unit's busyFlag input so the step counter holds while a CPU access is pending.

Parameters:
ADDR_W, 8, RAM address width
DATA_W, 8, RAM data width
RD_LAT, 1, RAM read latency in cycles from ram_en to valid ram_rdata (range 1..3)
STARVE_MAX, 4, consecutive CPU wins while the loader waits before the loader is forced to win (range 1..15)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
cpu_req  in  1  CPU transaction request, level, held until cpu_done
cpu_we  in  1  1=write, 0=read; stable while cpu_req=1
cpu_addr  in  ADDR_W  CPU address
cpu_wdata  in  DATA_W  CPU write data
cpu_rdata  out  DATA_W  CPU read data, valid when cpu_done=1, held until next CPU read completes
cpu_done  out  1  one-cycle completion pulse
cpu_busy  out  1  stall to CU busyFlag
ldr_req  in  1  loader request, level, held until ldr_done
ldr_we  in  1  loader write enable
ldr_addr  in  ADDR_W  loader address
ldr_wdata  in  DATA_W  loader write data
ldr_rdata  out  DATA_W  loader read data, valid with ldr_done
ldr_done  out  1  one-cycle completion pulse
ldr_lock  in  1  1=loader has exclusive ownership (boot in progress)
ram_en  out  1  RAM access enable
ram_we  out  1  RAM write strobe
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data
owner  out  2  00 none, 01 CPU, 10 loader

Behaviour:

Reset and registered outputs:
- While reset=0, all outputs are 0. This includes cpu_rdata and ldr_rdata.
- On reset: FSM returns to IDLE, starve_cnt=0.
- An in-flight transaction is dropped: no done pulse, ram_en/ram_we deassert immediately.
- Every output except cpu_busy is registered.

States: IDLE, WR, RD, RD_WAIT.

IDLE:
- owner=00, ram_en=0.
- At the clock edge, a winner is chosen from the requests sampled in that cycle. Requests are ignored in any cycle where that requester's done=1.

Arbitration:
- ldr_lock=1: only the loader is eligible.
- Otherwise, the loader wins if ldr_req=1 and either cpu_req=0 or starve_cnt==STARVE_MAX. In every other case with cpu_req=1, the CPU wins.
- starve_cnt increments, saturating at STARVE_MAX, when the CPU wins while ldr_req=1. It clears when the loader wins.
- At the grant edge, the winner's addr, wdata and we are latched to ram_*, owner is set, and the FSM enters WR or RD.

WR (cycle N+1 after the IDLE sample cycle N):
- ram_en=1, ram_we=1, done=1 to the owner.
- Next state is IDLE.
- Write latency: done in cycle N+1.

RD:
- ram_en=1, ram_we=0 for one cycle, then RD_WAIT.
- RD_WAIT counts down RD_LAT-1 cycles (zero cycles when RD_LAT=1).
- In the cycle ram_rdata is valid (N+RD_LAT), it is captured into the owner's rdata.
- done pulses in N+1+RD_LAT, together with a transition to IDLE.
- Read latency: done in N+2 for RD_LAT=1.

Back-to-back and requester rules:
- Back-to-back: minimum one IDLE cycle between transactions. The requester drops req, or presents a new transaction, in the cycle after done.
- Requesters keep we/addr/wdata stable from req rise until done. The arbiter does not re-sample them after the grant.

cpu_busy (combinational):
- cpu_busy = (cpu_req & ~cpu_done) | ldr_lock.
- So the CU holds SC_inc from request until completion, and holds for the whole boot.

ldr_lock events:
- ldr_lock rising during a CPU transaction: that transaction completes normally, then only the loader is granted.
- ldr_lock falling: normal arbitration from the next IDLE.

Other rules:
- Addresses are passed through unmodified. There is no wrap or decode; special addresses (UART 0xFE/0xFF) never reach this block.
- The owner's done and rdata update in the same cycle. The other requester's outputs are unchanged.

Test Plan:
- CPU write only: cpu_req=1, we=1, addr=0x10, wdata=0xA5 at cycle 0. Required: ram_en=ram_we=1, ram_addr=0x10, ram_wdata=0xA5, cpu_done=1 all in cycle 1; cpu_busy=1 in cycle 0, 0 in cycle 1.
- CPU read, RD_LAT=1: RAM[0x20]=0x3C, read at cycle 0. Required: ram_en=1, we=0 in cycle 1; cpu_done=1 and cpu_rdata=0x3C in cycle 2; repeat with RD_LAT=3 and require done in cycle 4.
- Simultaneous requests: both requesters issue continuous back-to-back writes, STARVE_MAX=4. Required: 4 CPU grants, then 1 loader grant, starve_cnt=0, then CPU again; owner sequence 01,01,01,01,10.
- Boot lock: ldr_lock=1 raised mid CPU read. Required: CPU read completes with correct data; a following cpu_req stays ungranted with cpu_busy=1 while 8 loader writes to 0x00..0x07 complete; after lock drops, the CPU is granted at the next IDLE.
- Reset mid-read: reset=0 in cycle 1 of a CPU read. Required: all outputs 0 immediately, no cpu_done; after release with req still high, the read re-arbitrates and completes with correct data.
